// File: rtl/logic_unit_sliced.sv
// rtl/logic_unit_sliced.sv - multi-cycle sliced logic/compare unit, MS slice first
// Compares terminate early on the first unequal slice; logic ops always walk every slice.
module logic_unit_sliced #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] logic_out,
  output logic [2:0]            logic_out_flag
);

  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [2:0]            r_op;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_out;
  logic [2:0]            r_flag;

  logic [SLICE_WIDTH-1:0] w_a_s;
  logic [SLICE_WIDTH-1:0] w_b_s;
  logic [SLICE_WIDTH-1:0] w_res_s;
  logic                   w_top;
  logic                   w_last;
  logic                   w_is_cmp;
  logic                   w_gt;
  logic                   w_lt;

  assign in_ready       = (r_state == S_IDLE) && !rst;
  assign out_valid      = (r_state == S_DONE);
  assign logic_out      = r_out;
  assign logic_out_flag = r_flag;

  always_comb begin
    w_a_s    = r_a[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH];
    w_b_s    = r_b[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH];
    w_top    = (r_idx == IDX_W'(NUM_SLICES - 1));
    w_last   = (r_idx == '0);
    w_is_cmp = (r_op == 3'd5) || (r_op == 3'd6);
    // Only the slice holding the sign bit is signed; lower slices are magnitude digits.
    if (r_op == 3'd6 && w_top) begin
      w_gt = $signed(w_a_s) > $signed(w_b_s);
      w_lt = $signed(w_a_s) < $signed(w_b_s);
    end else begin
      w_gt = w_a_s > w_b_s;
      w_lt = w_a_s < w_b_s;
    end
    case (r_op)
      3'd0:    w_res_s = w_a_s & w_b_s;
      3'd1:    w_res_s = w_a_s | w_b_s;
      3'd2:    w_res_s = w_a_s ^ w_b_s;
      3'd3:    w_res_s = ~w_a_s;
      3'd4:    w_res_s = ~w_b_s;
      default: w_res_s = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_idx   <= '0;
      r_out   <= '0;
      r_flag  <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_opcode;
            r_idx   <= IDX_W'(NUM_SLICES - 1);
            r_out   <= '0;
            r_flag  <= 3'b000;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_is_cmp) begin
            if (w_gt) begin
              r_flag  <= 3'b010;
              r_state <= S_DONE;
            end else if (w_lt) begin
              r_flag  <= 3'b001;
              r_state <= S_DONE;
            end else if (w_last) begin
              r_flag  <= 3'b100;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx - IDX_W'(1);
            end
          end else begin
            r_out[int'(r_idx)*SLICE_WIDTH +: SLICE_WIDTH] <= w_res_s;
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_sliced.sv
// tb/tb_logic_unit_sliced.sv - directed self-checking bench for logic_unit_sliced
module tb_logic_unit_sliced;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] logic_out;
  logic [2:0]  logic_out_flag;

  int n_cmp = 0;
  int n_err = 0;

  logic_unit_sliced #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .logic_out(logic_out), .logic_out_flag(logic_out_flag)
  );

  always #5 clk = ~clk;

  // Drives one request and returns edges from acceptance to out_valid (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int n;
    in_opcode = op; in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) begin lat = i - 1; break; end
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic [2:0] exp_flag, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    run_op(op, a, b, lat);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (logic_out !== exp_out) begin
      n_err++; $display("FAIL %s logic_out: got %h want %h", name, logic_out, exp_out);
    end
    n_cmp++;
    if (logic_out_flag !== exp_flag) begin
      n_err++; $display("FAIL %s flag: got %b want %b", name, logic_out_flag, exp_flag);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s return_idle: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || logic_out !== 32'h0 || logic_out_flag !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b out=%h flag=%b want 0/0/0/000",
                 in_ready, out_valid, logic_out, logic_out_flag);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_logic_ops();
    check_op("and",  3'd0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 3'b000, 4);
    n_cmp++;
    if (logic_out !== 32'hF000_1200) begin
      n_err++; $display("FAIL and_hold_idle: got %h want f0001200", logic_out);
    end
    check_op("or",   3'd1, 32'hA5A5_0000, 32'h0F0F_00F0, 32'hAFAF_00F0, 3'b000, 4);
    check_op("xor",  3'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 3'b000, 4);
    check_op("nota", 3'd3, 32'h1234_5678, 32'h0,         32'hEDCB_A987, 3'b000, 4);
    check_op("notb", 3'd4, 32'h0,         32'h0000_00FF, 32'hFFFF_FF00, 3'b000, 4);
    check_op("rsvd", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         3'b000, 4);
  endtask

  task automatic test_compare();
    check_op("cpr_gt_early", 3'd5, 32'h1200_0000, 32'h1100_FFFF, 32'h0, 3'b010, 1);
    check_op("cpr_eq",       3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 3'b100, 4);
    check_op("cpr_lt_s1",    3'd5, 32'h0000_1000, 32'h0000_2000, 32'h0, 3'b001, 3);
    check_op("cprs_neg",     3'd6, 32'h8000_0000, 32'h0000_0001, 32'h0, 3'b001, 1);
    check_op("cpr_uns",      3'd5, 32'h8000_0000, 32'h0000_0001, 32'h0, 3'b010, 1);
    check_op("cprs_bothneg", 3'd6, 32'hFF00_0000, 32'h8000_0000, 32'h0, 3'b010, 1);
    check_op("cprs_low_uns", 3'd6, 32'h0000_0080, 32'h0000_0001, 32'h0, 3'b010, 4);
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    run_op(3'd2, 32'h1234_5678, 32'hFFFF_0000, lat);
    n_cmp++;
    if (lat !== 4 || logic_out !== 32'hEDCB_5678) begin
      n_err++; $display("FAIL bp_xor: lat=%0d out=%h want 4/edcb5678", lat, logic_out);
    end
    in_opcode = 3'd1; in_a = 32'hAAAA_5555; in_b = 32'h0F0F_0F0F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || logic_out !== 32'hEDCB_5678 || logic_out_flag !== 3'b000) begin
        n_err++;
        $display("FAIL bp_hold: out_valid=%b in_ready=%b out=%h flag=%b want 1/0/edcb5678/000",
                 out_valid, in_ready, logic_out, logic_out_flag);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || logic_out !== 32'h0) begin
      n_err++; $display("FAIL bp_accept: out_valid=%b in_ready=%b out=%h want 0/0/0", out_valid, in_ready, logic_out);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    n_cmp++;
    if (lat !== 4 || logic_out !== 32'hAFAF_5F5F) begin
      n_err++; $display("FAIL bp_second: lat=%0d out=%h want 4/afaf5f5f", lat, logic_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    bit pulsed;
    out_ready = 1'b1;
    in_opcode = 3'd1; in_a = 32'h1234_5678; in_b = 32'h8000_0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || logic_out !== 32'h0 || logic_out_flag !== 3'b000) begin
      n_err++;
      $display("FAIL rst_busy: out_valid=%b in_ready=%b out=%h flag=%b want 0/0/0/000",
               out_valid, in_ready, logic_out, logic_out_flag);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulsed = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulsed = 1'b1;
    end
    n_cmp++;
    if (pulsed !== 1'b0) begin
      n_err++; $display("FAIL rst_busy_no_pulse: pulsed=%b want 0", pulsed);
    end
    check_op("and_after_rst", 3'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 3'b000, 4);
  endtask

  initial begin
    test_reset();
    test_logic_ops();
    test_compare();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
